// File: rtl/ventana_3x3.sv
// rtl/ventana_3x3.sv - 3x3 window builder over a raster stream plus two line-delayed rows.
// Tracks column/row to flag only in-image windows and pulses frame_done after the last pixel.
module ventana_3x3 #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_DIM_BITS = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [MAX_DIM_BITS-1:0] image_width,
    input  logic [MAX_DIM_BITS-1:0] image_height,
    input  logic                    pixel_valid,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic [DATA_WIDTH-1:0]   row1_in,
    input  logic [DATA_WIDTH-1:0]   row2_in,
    output logic [9*DATA_WIDTH-1:0] window_out,
    output logic                    window_valid,
    output logic                    frame_done,
    output logic                    no_config,
    output logic                    config_error
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic {E_ESPERA_CONFIG, E_PROCESANDO} estado_t;

    estado_t                 state_q, state_d;
    logic [MAX_DIM_BITS-1:0] width_q, width_d;
    logic [MAX_DIM_BITS-1:0] height_q, height_d;
    logic [MAX_DIM_BITS-1:0] col_q, col_d;
    logic [MAX_DIM_BITS-1:0] row_q, row_d;
    logic [9*DW-1:0]         win_q, win_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= E_ESPERA_CONFIG;
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            E_ESPERA_CONFIG: begin
                if (start) begin
                    if (image_width >= MAX_DIM_BITS'(3) && image_height >= MAX_DIM_BITS'(3)) begin
                        width_d  = image_width;
                        height_d = image_height;
                        col_d    = '0;
                        row_d    = '0;
                        err_d    = 1'b0;
                        state_d  = E_PROCESANDO;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            E_PROCESANDO: begin
                if (pixel_valid) begin
                    // Element r*3+c; column 2 is the newest, column 0 the oldest.
                    for (int r = 0; r < 3; r++) begin
                        win_d[(3*r)*DW +: DW]   = win_q[(3*r+1)*DW +: DW];
                        win_d[(3*r+1)*DW +: DW] = win_q[(3*r+2)*DW +: DW];
                    end
                    win_d[2*DW +: DW] = row2_in;
                    win_d[5*DW +: DW] = row1_in;
                    win_d[8*DW +: DW] = pixel_in;
                    valid_d = (col_q >= MAX_DIM_BITS'(2)) && (row_q >= MAX_DIM_BITS'(2));
                    if (col_q == width_q - MAX_DIM_BITS'(1)) begin
                        col_d = '0;
                        if (row_q == height_q - MAX_DIM_BITS'(1)) begin
                            row_d  = '0;
                            done_d = 1'b1;
                        end else begin
                            row_d = row_q + MAX_DIM_BITS'(1);
                        end
                    end else begin
                        col_d = col_q + MAX_DIM_BITS'(1);
                    end
                end
            end
            default: state_d = E_ESPERA_CONFIG;
        endcase
    end

    assign window_out   = win_q;
    assign window_valid = valid_q;
    assign frame_done   = done_q;
    assign no_config    = (state_q == E_ESPERA_CONFIG);
    assign config_error = err_q;
endmodule

// File: tb/tb_ventana_3x3.sv
// tb/tb_ventana_3x3.sv - directed and randomized frames for ventana_3x3 against a column-history model.
module tb_ventana_3x3;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] image_width;
    logic [10:0] image_height;
    logic        pixel_valid;
    logic [7:0]  pixel_in;
    logic [7:0]  row1_in;
    logic [7:0]  row2_in;
    logic [71:0] window_out;
    logic        window_valid;
    logic        frame_done;
    logic        no_config;
    logic        config_error;

    int          total = 0;
    int          bad = 0;
    int          vcount = 0;
    logic [23:0] hist [3];
    bit          configured = 0;
    bit          cfg_err = 0;

    ventana_3x3 #(.DATA_WIDTH(8), .MAX_DIM_BITS(11)) dut (
        .clk(clk), .reset(reset), .start(start),
        .image_width(image_width), .image_height(image_height),
        .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .row1_in(row1_in), .row2_in(row2_in),
        .window_out(window_out), .window_valid(window_valid),
        .frame_done(frame_done), .no_config(no_config),
        .config_error(config_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Window = last three accepted columns; each column holds {pixel, row1, row2}.
    function automatic logic [71:0] exp_win();
        logic [71:0] w;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                w[(r*3+c)*8 +: 8] = hist[c][r*8 +: 8];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        configured = 0;
        cfg_err    = 0;
    endtask

    task automatic do_cycle(input bit v, input logic [7:0] p, input logic [7:0] r1,
                            input logic [7:0] r2, input bit s, input bit ev, input bit ed);
        bit acc;
        @(negedge clk);
        pixel_valid = v; pixel_in = p; row1_in = r1; row2_in = r2; start = s;
        acc = v && configured;
        if (!configured && s) begin
            if (image_width >= 3 && image_height >= 3) begin
                configured = 1;
                cfg_err    = 0;
            end else begin
                cfg_err = 1;
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            hist[0] = hist[1];
            hist[1] = hist[2];
            hist[2] = {p, r1, r2};
        end
        if (window_valid === 1'b1) vcount++;
        chk("window_valid", window_valid, ev && acc);
        chk("frame_done", frame_done, ed && acc);
        chk("window_out", window_out, exp_win());
        chk("no_config", no_config, !configured);
        chk("config_error", config_error, cfg_err);
        start = 0;
        pixel_valid = 0;
    endtask

    task automatic run_frame(input int w, input int h, input int on, input int off,
                             input bit det, input int st_at, input int abort_at);
        logic [7:0]  img [8][8];
        logic [7:0]  r1, r2;
        logic [71:0] first;
        int idx = 0;
        int run = 0;
        first = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
        vcount = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = det ? 8'(r*16 + c) : 8'($urandom);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                r1 = (r >= 1) ? img[r-1][c] : 8'($urandom);
                r2 = (r >= 2) ? img[r-2][c] : 8'($urandom);
                do_cycle(1, img[r][c], r1, r2, idx == st_at, r >= 2 && c >= 2,
                         r == h-1 && c == w-1);
                if (det && r == 2 && c == 2) chk("first_window", window_out, first);
                if (idx == abort_at) return;
                idx++;
                if (off > 0 && ++run == on) begin
                    run = 0;
                    repeat (off) do_cycle(0, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0);
                end
            end
        end
        chk("valid_count", 72'(vcount), 72'((w-2)*(h-2)));
    endtask

    task automatic async_reset_check();
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_window", window_out, 72'h0);
        chk("rst_valid", window_valid, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_no_config", no_config, 1'b1);
        chk("rst_config_error", config_error, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 0; pixel_valid = 0;
        pixel_in = 0; row1_in = 0; row2_in = 0;
        image_width = 11'd4; image_height = 11'd4;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_window", window_out, 72'h0);
        chk("init_valid", window_valid, 1'b0);
        chk("init_no_config", no_config, 1'b1);
        chk("init_config_error", config_error, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Pixels before any configuration are ignored; bad start rejected; good start with pixel ignored.
        do_cycle(1, 8'hAA, 8'hBB, 8'hCC, 0, 0, 0);
        image_width = 11'd2; image_height = 11'd5;
        do_cycle(1, 8'h11, 8'h22, 8'h33, 1, 0, 0);
        image_width = 11'd4; image_height = 11'd4;
        do_cycle(1, 8'h44, 8'h55, 8'h66, 1, 0, 0);

        run_frame(4, 4, 1, 0, 1, -1, -1);
        image_width = 11'd8; image_height = 11'd8;
        run_frame(4, 4, 1, 2, 1, 5, -1);
        run_frame(4, 4, 2, 1, 0, 9, -1);

        // Reset mid-row in row 2, then pixels without a new start produce nothing.
        run_frame(4, 4, 1, 0, 0, -1, 9);
        async_reset_check();
        repeat (5) do_cycle(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0);

        image_width = 11'd5; image_height = 11'd3;
        do_cycle(0, 0, 0, 0, 1, 0, 0);
        run_frame(5, 3, 1, 0, 0, -1, -1);
        run_frame(5, 3, 1, 0, 0, -1, -1);

        for (int t = 0; t < 4; t++) begin
            int w, h, on, off;
            w   = $urandom_range(3, 7);
            h   = $urandom_range(3, 7);
            on  = $urandom_range(1, 3);
            off = $urandom_range(0, 2);
            @(negedge clk);
            async_reset_check();
            image_width = 11'(w); image_height = 11'(h);
            do_cycle(0, 0, 0, 0, 1, 0, 0);
            run_frame(w, h, on, off, 0, -1, -1);
            run_frame(w, h, on, off, 0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ventana_3x3.md
# ventana_3x3

Builds a 3×3 pixel neighbourhood from a raster pixel stream and the two line-delayed streams produced by the row-buffer chain (configurable FIFO line buffers). It sits directly downstream of the row buffers and feeds the filter arithmetic. It tracks column and row position so that only windows lying fully inside the image are flagged valid, and it signals end of frame.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- MAX_DIM_BITS, 11, width of the image-dimension inputs and counters (max 2047)

- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle pulse; latches image_width/image_height when waiting for configuration
- image_width  input  MAX_DIM_BITS  pixels per row, valid range 3..2^MAX_DIM_BITS-1
- image_height  input  MAX_DIM_BITS  rows per frame, valid range 3..2^MAX_DIM_BITS-1
- pixel_valid  input  1  the current-row, row1 and row2 inputs carry one aligned column this cycle
- pixel_in  input  DATA_WIDTH  current-row pixel (bottom row of window)
- row1_in  input  DATA_WIDTH  same column, one line earlier (middle row)
- row2_in  input  DATA_WIDTH  same column, two lines earlier (top row)
- window_out  output  9*DATA_WIDTH  element k=r*3+c at bits [k*DATA_WIDTH +: DATA_WIDTH]; r=0 top, c=0 leftmost/oldest column
- window_valid  output  1  window_out holds an in-image window this cycle
- frame_done  output  1  one-cycle pulse after the last pixel of a frame
- no_config  output  1  high while no valid configuration is latched
- config_error  output  1  sticky; set by a start with width or height < 3

## Operation
- States: E_ESPERA_CONFIG (reset state), E_PROCESANDO.
- E_ESPERA_CONFIG: pixel_valid ignored (no shift, no counting). On start: if image_width>=3 and image_height>=3, latch both, clear counters, clear config_error, go to E_PROCESANDO; otherwise set config_error, stay.
- E_PROCESANDO: start ignored. Each pixel_valid cycle:
  - shift each window row left: w[r][0]<=w[r][1], w[r][1]<=w[r][2]; w[0][2]<=row2_in, w[1][2]<=row1_in, w[2][2]<=pixel_in.
  - window_valid next cycle = (col>=2 && row>=2), using counter values before increment.
  - col increments; at col==width-1 it wraps to 0 and row increments; at row==height-1 with col==width-1 both wrap to 0 and frame_done pulses next cycle. State remains E_PROCESANDO; the next frame reuses the latched configuration.
- Shift registers are not cleared at row wrap; the first two columns of each row are masked by the col>=2 condition.
- Cycles without pixel_valid: window_out holds, window_valid=0, counters hold.
- no_config = (state==E_ESPERA_CONFIG).
- Counters compare against the latched values only; changing image_width/height inputs mid-frame has no effect.

## Timing
- Reset (async assert, any time including mid-frame): state=E_ESPERA_CONFIG, counters=0, window_out=0, window_valid=0, frame_done=0, no_config=1, config_error=0. Deassertion is synchronous to clk by the surrounding system.
- Latency: pixel accepted on edge N → window_out/window_valid updated after edge N, observable during cycle N+1; frame_done is simultaneous with window_valid of the bottom-right window.
- start accepted on edge N → no_config low from cycle N+1; a pixel_valid on the same edge as start is ignored.
- Throughput: one pixel per clock, no back-pressure; pixel_valid may be asserted every cycle.
- Valid windows per frame: (width-2)*(height-2).

## Test plan
- Config reject: start with width=2, height=5 → config_error=1, no_config stays 1; then start 4×4 → config_error=0, no_config=0 next cycle.
- 4×4 frame, pixel values = row*16+col, continuous pixel_valid, row1/row2 fed the corresponding earlier rows → exactly 4 window_valid pulses; first window_out = {0x00,0x01,0x02 / 0x10,0x11,0x12 / 0x20,0x21,0x22} (top-left to bottom-right); frame_done coincides with the 4th valid.
- Same frame with pixel_valid gaps (1 on, 2 off) → identical window sequence, window_valid only after accepted pixels, counters hold during gaps.
- Back-to-back frames 5×3 → 3 valids each frame, frame_done twice, second frame's first valid occurs at its 3rd pixel of row 2 (no stale windows from row wrap).
- Reset asserted mid-row in row 2 → all outputs to reset values immediately (asynchronous); pixel_valid afterwards produces no windows until a new start.
- start pulsed during E_PROCESANDO with 8×8 → ignored; current 4×4 framing continues unchanged.
